// File: rtl/riscv_csr_ctrl_pkg.sv
// Shared constants for the CSR sequencer: op codes, CSR addresses, trap cause and FSM states.
// RISCV_CSR_CTRL_MSTATUS_EN adds the MSTATUS update states and bit positions.
package riscv_csr_ctrl_pkg;

  typedef enum logic [2:0] {
    CSR_OP_NONE  = 3'd0,
    CSR_OP_RW    = 3'd1,
    CSR_OP_RS    = 3'd2,
    CSR_OP_RC    = 3'd3,
    CSR_OP_ECALL = 3'd4,
    CSR_OP_MRET  = 3'd5
  } csr_op_e;

  localparam logic [11:0] CSR_MTVEC  = 12'h305;
  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;

  localparam int unsigned CAUSE_ECALL_M = 11;

`ifdef RISCV_CSR_CTRL_MSTATUS_EN
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MSTATUS_MPP_LO   = 11;
  localparam int MSTATUS_MPP_HI   = 12;
`endif

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_T_EPC,
    ST_T_CAUSE,
`ifdef RISCV_CSR_CTRL_MSTATUS_EN
    ST_T_MSTAT,
    ST_M_MSTAT,
`endif
    ST_T_VEC,
    ST_M_EPC,
    ST_ERR
  } ctrl_state_e;

endpackage

// File: rtl/riscv_csr_ctrl_alu.sv
// Zicsr read-modify-write datapath: new CSR value and whether a write is architecturally required.
module riscv_csr_ctrl_alu
  import riscv_csr_ctrl_pkg::*;
#(
  parameter int WORD_LENGTH = 32
) (
  input  logic [2:0]             op,
  input  logic [WORD_LENGTH-1:0] old_val,
  input  logic [WORD_LENGTH-1:0] wdata,
  output logic [WORD_LENGTH-1:0] new_val,
  output logic                   write_needed
);

  always_comb begin
    new_val      = old_val;
    write_needed = 1'b0;
    case (op)
      CSR_OP_RW: begin
        new_val      = wdata;
        write_needed = 1'b1;
      end
      CSR_OP_RS: begin
        new_val      = old_val | wdata;
        write_needed = |wdata;
      end
      // A zero mask turns set/clear into a pure read with no side effects.
      CSR_OP_RC: begin
        new_val      = old_val & ~wdata;
        write_needed = |wdata;
      end
      default: begin
        new_val      = old_val;
        write_needed = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/riscv_csr_ctrl.sv
// Sequencer serialising Zicsr RMW, ECALL trap entry and MRET onto a single CSR file port.
// Defining RISCV_CSR_CTRL_MSTATUS_EN adds MSTATUS MIE/MPIE/MPP handling on trap entry and return.
module riscv_csr_ctrl
  import riscv_csr_ctrl_pkg::*;
#(
  parameter int WORD_LENGTH = 32,
  parameter int CSR_ADDR_W  = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [2:0]             req_op,
  input  logic [CSR_ADDR_W-1:0]  req_addr,
  input  logic [WORD_LENGTH-1:0] req_wdata,
  input  logic [WORD_LENGTH-1:0] req_pc,
  output logic                   resp_valid,
  output logic [WORD_LENGTH-1:0] resp_rdata,
  output logic                   redirect_valid,
  output logic [WORD_LENGTH-1:0] redirect_pc,
  output logic                   csr_we,
  output logic [CSR_ADDR_W-1:0]  csr_addr,
  output logic [WORD_LENGTH-1:0] csr_wdata,
  input  logic [WORD_LENGTH-1:0] csr_rdata
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready; req_ready is
  // high only in IDLE, and resp_valid/redirect_valid are single-cycle pulses with no back-pressure.

  ctrl_state_e            state_q, state_d;
  logic [2:0]             op_q, op_d;
  logic [CSR_ADDR_W-1:0]  addr_q, addr_d;
  logic [WORD_LENGTH-1:0] wdata_q, wdata_d;
  logic [WORD_LENGTH-1:0] pc_q, pc_d;
  logic [WORD_LENGTH-1:0] old_q, old_d;
  logic [WORD_LENGTH-1:0] alu_new;
  logic                   alu_write;

  riscv_csr_ctrl_alu #(.WORD_LENGTH(WORD_LENGTH)) u_alu (
    .op           (op_q),
    .old_val      (old_q),
    .wdata        (wdata_q),
    .new_val      (alu_new),
    .write_needed (alu_write)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    pc_d    = pc_q;
    old_d   = old_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          pc_d    = req_pc;
          case (req_op)
            CSR_OP_RW, CSR_OP_RS, CSR_OP_RC: state_d = ST_RD;
            CSR_OP_ECALL:                    state_d = ST_T_EPC;
`ifdef RISCV_CSR_CTRL_MSTATUS_EN
            CSR_OP_MRET:                     state_d = ST_M_MSTAT;
`else
            CSR_OP_MRET:                     state_d = ST_M_EPC;
`endif
            default:                         state_d = ST_ERR;
          endcase
        end
      end
      ST_RD: begin
        old_d   = csr_rdata;
        state_d = ST_WR;
      end
      ST_T_EPC: state_d = ST_T_CAUSE;
`ifdef RISCV_CSR_CTRL_MSTATUS_EN
      ST_T_CAUSE: state_d = ST_T_MSTAT;
      ST_T_MSTAT: state_d = ST_T_VEC;
      ST_M_MSTAT: state_d = ST_M_EPC;
`else
      ST_T_CAUSE: state_d = ST_T_VEC;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_rdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    csr_we         = 1'b0;
    csr_addr       = '0;
    csr_wdata      = '0;
    case (state_q)
      ST_IDLE: req_ready = 1'b1;
      ST_RD:   csr_addr  = addr_q;
      ST_WR: begin
        csr_addr   = addr_q;
        csr_we     = alu_write;
        csr_wdata  = alu_new;
        resp_valid = 1'b1;
        resp_rdata = old_q;
      end
      ST_T_EPC: begin
        csr_we    = 1'b1;
        csr_addr  = CSR_ADDR_W'(CSR_MEPC);
        csr_wdata = pc_q;
      end
      ST_T_CAUSE: begin
        csr_we    = 1'b1;
        csr_addr  = CSR_ADDR_W'(CSR_MCAUSE);
        csr_wdata = WORD_LENGTH'(CAUSE_ECALL_M);
      end
`ifdef RISCV_CSR_CTRL_MSTATUS_EN
      ST_T_MSTAT: begin
        csr_we    = 1'b1;
        csr_addr  = CSR_ADDR_W'(CSR_MSTATUS);
        csr_wdata = csr_rdata;
        csr_wdata[MSTATUS_MPIE_BIT] = csr_rdata[MSTATUS_MIE_BIT];
        csr_wdata[MSTATUS_MIE_BIT]  = 1'b0;
        csr_wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      end
      ST_M_MSTAT: begin
        csr_we    = 1'b1;
        csr_addr  = CSR_ADDR_W'(CSR_MSTATUS);
        csr_wdata = csr_rdata;
        csr_wdata[MSTATUS_MIE_BIT]  = csr_rdata[MSTATUS_MPIE_BIT];
        csr_wdata[MSTATUS_MPIE_BIT] = 1'b1;
      end
`endif
      // Vector is forced to direct mode by clearing the MODE bits.
      ST_T_VEC: begin
        csr_addr       = CSR_ADDR_W'(CSR_MTVEC);
        redirect_pc    = {csr_rdata[WORD_LENGTH-1:2], 2'b00};
        redirect_valid = 1'b1;
        resp_valid     = 1'b1;
      end
      ST_M_EPC: begin
        csr_addr       = CSR_ADDR_W'(CSR_MEPC);
        redirect_pc    = {csr_rdata[WORD_LENGTH-1:1], 1'b0};
        redirect_valid = 1'b1;
        resp_valid     = 1'b1;
      end
      ST_ERR: resp_valid = 1'b1;
      default: req_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      pc_q    <= '0;
      old_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      pc_q    <= pc_d;
      old_q   <= old_d;
    end
  end

endmodule

// File: tb/tb_riscv_csr_ctrl.sv
// Self-checking bench for riscv_csr_ctrl: directed vector table, hand-written multi-cycle
// sequences and randomized ops against a behavioural CSR-file model.
module tb_riscv_csr_ctrl;

  localparam int W  = 32;
  localparam int AW = 12;
`ifdef RISCV_CSR_CTRL_MSTATUS_EN
  localparam int EN = 1;
`else
  localparam int EN = 0;
`endif
  localparam int LAT_E = 3 + EN;
  localparam int LAT_M = 1 + EN;
  localparam int WE_E  = 2 + EN;
  localparam int WE_M  = EN;

  localparam logic [2:0] OP_RW    = 3'd1;
  localparam logic [2:0] OP_RS    = 3'd2;
  localparam logic [2:0] OP_RC    = 3'd3;
  localparam logic [2:0] OP_ECALL = 3'd4;
  localparam logic [2:0] OP_MRET  = 3'd5;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MSCR    = 12'h340;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_CUST    = 12'h7C0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_op = '0;
  logic [AW-1:0] req_addr = '0;
  logic [W-1:0]  req_wdata = '0;
  logic [W-1:0]  req_pc = '0;
  logic          resp_valid;
  logic [W-1:0]  resp_rdata;
  logic          redirect_valid;
  logic [W-1:0]  redirect_pc;
  logic          csr_we;
  logic [AW-1:0] csr_addr;
  logic [W-1:0]  csr_wdata;
  logic [W-1:0]  csr_rdata;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  riscv_csr_ctrl #(.WORD_LENGTH(W), .CSR_ADDR_W(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_pc         (req_pc),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .csr_we         (csr_we),
    .csr_addr       (csr_addr),
    .csr_wdata      (csr_wdata),
    .csr_rdata      (csr_rdata)
  );

  // CSR file attached to the DUT port, plus a bench-side preload port used only while idle.
  logic [W-1:0]  csr_mem [4096];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [W-1:0]  pl_val = '0;
  assign csr_rdata = csr_mem[csr_addr];
  always @(posedge clk) begin
    if (csr_we) csr_mem[csr_addr] <= csr_wdata;
    else if (pl_en) csr_mem[pl_addr] <= pl_val;
  end

  // ---------------- scoreboard / reference model ----------------
  logic [W-1:0] ref_mem [4096];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_op(input logic [2:0] op, input logic [11:0] a, input logic [W-1:0] wd,
                          input logic [W-1:0] pc, output int lat, output logic [W-1:0] rd,
                          output logic rv, output logic [W-1:0] rpc, output int we);
    logic [W-1:0] old, m;
    lat = 1; rd = '0; rv = 1'b0; rpc = '0; we = 0;
    case (op)
      OP_RW, OP_RS, OP_RC: begin
        old = ref_mem[a];
        lat = 2;
        rd  = old;
        if (op == OP_RW || wd != 0) begin
          we = 1;
          if (op == OP_RW)      ref_mem[a] = wd;
          else if (op == OP_RS) ref_mem[a] = old | wd;
          else                  ref_mem[a] = old & ~wd;
        end
      end
      OP_ECALL: begin
        ref_mem[A_MEPC]   = pc;
        ref_mem[A_MCAUSE] = 32'd11;
        we = 2; lat = 3;
        if (EN == 1) begin
          m = ref_mem[A_MSTATUS];
          m[7] = m[3]; m[3] = 1'b0; m[12:11] = 2'b11;
          ref_mem[A_MSTATUS] = m;
          we = 3; lat = 4;
        end
        rv  = 1'b1;
        rpc = ref_mem[A_MTVEC] & ~32'h3;
      end
      OP_MRET: begin
        if (EN == 1) begin
          m = ref_mem[A_MSTATUS];
          m[3] = m[7]; m[7] = 1'b1;
          ref_mem[A_MSTATUS] = m;
          we = 1; lat = 2;
        end
        rv  = 1'b1;
        rpc = ref_mem[A_MEPC] & ~32'h1;
      end
      default: begin
        lat = 1;
      end
    endcase
  endtask

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [11:0] a, input logic [W-1:0] v);
    @(negedge clk);
    pl_addr = a; pl_val = v; pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
    ref_mem[a] = v;
  endtask

  // Issues one request and observes it until its response; lat=0 means no response seen.
  task automatic run_op(input logic [2:0] op, input logic [11:0] a, input logic [W-1:0] wd,
                        input logic [W-1:0] pc, output int lat, output logic [W-1:0] rd,
                        output logic rv, output logic [W-1:0] rpc, output int we,
                        output int busy_ready);
    int g;
    @(negedge clk);
    g = 0;
    while (!req_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("ready_before_issue", {31'd0, req_ready}, 32'd1);
    req_op = op; req_addr = a; req_wdata = wd; req_pc = pc; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0; rd = '0; rv = 1'b0; rpc = '0; we = 0; busy_ready = 0;
    for (int k = 1; k <= 8; k++) begin
      if (csr_we) we++;
      if (resp_valid) begin
        lat = k; rd = resp_rdata; rv = redirect_valid; rpc = redirect_pc;
        break;
      end
      if (req_ready) busy_ready++;
      @(negedge clk);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [2:0]   op;
    logic [11:0]  addr;
    logic [W-1:0] wdata;
    logic [W-1:0] pc;
    logic [11:0]  pre_addr;
    logic [W-1:0] pre_val;
    int           exp_lat;
    logic [W-1:0] exp_rd;
    logic         exp_rv;
    logic [W-1:0] exp_rpc;
    int           exp_we;
    logic [11:0]  chk_addr;
    logic [W-1:0] chk_val;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];
  logic [11:0] addr_set [6];

  initial begin
    int lat, we, br, m_lat, m_we, acc, rsp, rdr;
    logic [W-1:0] rd, rpc, m_rd, m_rpc, rpc_ecall;
    logic rv, m_rv;
    logic [2:0] op;
    logic [11:0] a;
    logic [W-1:0] wd, pc;

    for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
    addr_set[0] = A_MSTATUS; addr_set[1] = A_MTVEC; addr_set[2] = A_MSCR;
    addr_set[3] = A_MEPC;    addr_set[4] = A_MCAUSE; addr_set[5] = A_CUST;

    vecs[0] = '{OP_RW, A_MSCR, 32'h1234, 32'h0, A_MSCR, 32'hAAAA0000,
                2, 32'hAAAA0000, 1'b0, 32'h0, 1, A_MSCR, 32'h1234};
    vecs[1] = '{OP_RS, A_MSCR, 32'h0, 32'h0, A_MSCR, 32'h5555,
                2, 32'h5555, 1'b0, 32'h0, 0, A_MSCR, 32'h5555};
    vecs[2] = '{OP_RC, A_MSCR, 32'h0000FFFF, 32'h0, A_MSCR, 32'hFFFFFFFF,
                2, 32'hFFFFFFFF, 1'b0, 32'h0, 1, A_MSCR, 32'hFFFF0000};
    vecs[3] = '{OP_RS, A_MSTATUS, 32'h0F, 32'h0, A_MSTATUS, 32'hF0,
                2, 32'hF0, 1'b0, 32'h0, 1, A_MSTATUS, 32'hFF};
    vecs[4] = '{OP_RW, A_MSTATUS, 32'h80, 32'h0, A_MSTATUS, 32'h0,
                2, 32'h0, 1'b0, 32'h0, 1, A_MSTATUS, 32'h80};
    vecs[5] = '{OP_MRET, 12'h0, 32'h0, 32'h0, A_MEPC, 32'h85,
                LAT_M, 32'h0, 1'b1, 32'h84, WE_M, A_MSTATUS, (EN == 1) ? 32'h88 : 32'h80};
    vecs[6] = '{OP_ECALL, 12'h0, 32'h0, 32'h80, A_MTVEC, 32'h103,
                LAT_E, 32'h0, 1'b1, 32'h100, WE_E, A_MSTATUS, (EN == 1) ? 32'h1880 : 32'h80};
    vecs[7] = '{3'd0, A_CUST, 32'hFFFF, 32'h0, A_CUST, 32'h22,
                1, 32'h0, 1'b0, 32'h0, 0, A_CUST, 32'h22};
    vecs[8] = '{3'd7, A_MSCR, 32'h1, 32'h0, A_CUST, 32'h33,
                1, 32'h0, 1'b0, 32'h0, 0, A_MSCR, 32'hFFFF0000};
    vecs[9] = '{3'd6, A_MTVEC, 32'h0, 32'h0, A_CUST, 32'h44,
                1, 32'h0, 1'b0, 32'h0, 0, A_MTVEC, 32'h103};

    // Reset state, with the CSR file cleared through the preload port.
    for (int j = 0; j < 6; j++) preload(addr_set[j], 32'h0);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("rst_csr_we", {31'd0, csr_we}, 32'd0);
    chk("rst_csr_addr", {20'd0, csr_addr}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < NV; i++) begin
      preload(vecs[i].pre_addr, vecs[i].pre_val);
      model_op(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].pc, m_lat, m_rd, m_rv, m_rpc, m_we);
      run_op(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].pc, lat, rd, rv, rpc, we, br);
      @(negedge clk);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_resp_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("v%0d_redirect_valid", i), {31'd0, rv}, {31'd0, vecs[i].exp_rv});
      chk($sformatf("v%0d_redirect_pc", i), rpc, vecs[i].exp_rpc);
      chk($sformatf("v%0d_we_count", i), we, vecs[i].exp_we);
      chk($sformatf("v%0d_ready_while_busy", i), br, 32'd0);
      chk($sformatf("v%0d_csr_%03h", i, vecs[i].chk_addr), csr_mem[vecs[i].chk_addr], vecs[i].chk_val);
      if (vecs[i].op == OP_ECALL) begin
        chk($sformatf("v%0d_mepc", i), csr_mem[A_MEPC], vecs[i].pc);
        chk($sformatf("v%0d_mcause", i), csr_mem[A_MCAUSE], 32'd11);
      end
    end

    // req_valid held continuously: one accept and one response per MRET, 1 idle cycle between.
    preload(A_MEPC, 32'h201);
    @(negedge clk);
    req_op = OP_MRET; req_addr = '0; req_wdata = '0; req_pc = '0; req_valid = 1'b1;
    acc = 0; rsp = 0; rdr = 0;
    for (int k = 0; k < 3 * (LAT_M + 1); k++) begin
      if (req_valid && req_ready) acc++;
      if (resp_valid) rsp++;
      if (redirect_valid) begin
        rdr++;
        chk("hold_redirect_pc", redirect_pc, 32'h200);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    for (int k = 0; k < 3; k++) model_op(OP_MRET, 12'h0, 32'h0, 32'h0, m_lat, m_rd, m_rv, m_rpc, m_we);
    chk("hold_accepts", acc, 32'd3);
    chk("hold_resp_pulses", rsp, 32'd3);
    chk("hold_redirect_pulses", rdr, 32'd3);
    @(negedge clk);
    chk("hold_mstatus", csr_mem[A_MSTATUS], ref_mem[A_MSTATUS]);

    // Asynchronous reset during T_CAUSE: MEPC already written, MCAUSE must stay untouched.
    preload(A_MCAUSE, 32'hDEAD);
    @(negedge clk);
    req_op = OP_ECALL; req_pc = 32'h444; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rstmid_we_in_cause", {31'd0, csr_we}, 32'd1);
    chk("rstmid_addr_in_cause", {20'd0, csr_addr}, {20'd0, A_MCAUSE});
    rst_n = 1'b0;
    #1;
    chk("rstmid_we_drop", {31'd0, csr_we}, 32'd0);
    chk("rstmid_ready", {31'd0, req_ready}, 32'd1);
    chk("rstmid_resp", {31'd0, resp_valid}, 32'd0);
    chk("rstmid_redirect", {31'd0, redirect_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp = 0;
    for (int k = 0; k < 5; k++) begin
      if (resp_valid || redirect_valid || csr_we) rsp++;
      @(negedge clk);
    end
    chk("rstmid_no_activity_after", rsp, 32'd0);
    ref_mem[A_MEPC] = 32'h444;
    chk("rstmid_mepc_kept", csr_mem[A_MEPC], 32'h444);
    chk("rstmid_mcause_unwritten", csr_mem[A_MCAUSE], 32'hDEAD);

    // Randomized ops against the behavioural model.
    preload(A_MTVEC, $urandom());
    preload(A_MEPC, $urandom());
    for (int n = 0; n < 60; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = addr_set[$urandom_range(0, 5)];
      wd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom();
      pc = $urandom();
      model_op(op, a, wd, pc, m_lat, m_rd, m_rv, m_rpc, m_we);
      run_op(op, a, wd, pc, lat, rd, rv, rpc, we, br);
      @(negedge clk);
      chk($sformatf("r%0d_op%0d_latency", n, op), lat, m_lat);
      chk($sformatf("r%0d_op%0d_resp_rdata", n, op), rd, m_rd);
      chk($sformatf("r%0d_op%0d_redirect_valid", n, op), {31'd0, rv}, {31'd0, m_rv});
      chk($sformatf("r%0d_op%0d_redirect_pc", n, op), rpc, m_rpc);
      chk($sformatf("r%0d_op%0d_we_count", n, op), we, m_we);
      chk($sformatf("r%0d_op%0d_ready_while_busy", n, op), br, 32'd0);
      for (int j = 0; j < 6; j++)
        chk($sformatf("r%0d_csr_%03h", n, addr_set[j]), csr_mem[addr_set[j]], ref_mem[addr_set[j]]);
    end

    rpc_ecall = '0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + int'(rpc_ecall));
    $finish;
  end

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
